// File: rtl/hazard_sched_if.sv
// Hazard-scheduler bundle: hazard inputs from the ID/EX pipeline, stage controls back.
// master drives the pipeline-side inputs; slave is the scheduler.
interface hazard_sched_if;
  logic       start;
  logic [4:0] ifid_rs1;
  logic [4:0] ifid_rs2;
  logic       ifid_uses_rs2;
  logic [4:0] idex_rd;
  logic       idex_memread;
  logic       branch_taken;
  logic       dmem_busy;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       pipe_hold;
  logic [1:0] state;

  modport master (
    output start, ifid_rs1, ifid_rs2, ifid_uses_rs2, idex_rd, idex_memread,
           branch_taken, dmem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, state
  );

  modport slave (
    input  start, ifid_rs1, ifid_rs2, ifid_uses_rs2, idex_rd, idex_memread,
           branch_taken, dmem_busy,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, state
  );
endinterface

// File: rtl/hazard_sched.sv
// Pipeline sequencing controller: load-use stall stretching, branch flush, memory freeze.
// Same-cycle (Mealy) controls; HAZARD_SCHED_PERF_EN adds saturating stall/flush counters.
module hazard_sched #(
  parameter int unsigned STALL_CYCLES = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  hazard_sched_if.slave bus
`ifdef HAZARD_SCHED_PERF_EN
  ,
  output logic [31:0]   stall_cnt_o,
  output logic [31:0]   flush_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, LSTALL = 2'b10, MWAIT = 2'b11} state_e;
  typedef enum logic [1:0] {M_IDLE, M_NORMAL, M_STALL, M_FREEZE} mode_e;

  localparam logic [2:0] CNT_INIT = 3'(STALL_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  mode_e      mode;
  logic       flush_ok;
  logic       hz;

  assign hz = bus.idex_memread && (bus.idex_rd != 5'd0) &&
              ((bus.idex_rd == bus.ifid_rs1) ||
               (bus.ifid_uses_rs2 && (bus.idex_rd == bus.ifid_rs2)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode     = M_IDLE;
    flush_ok = 1'b0;
    if (!bus.start) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        IDLE: state_d = RUN;
        RUN: begin
          if (bus.dmem_busy) begin
            mode    = M_FREEZE;
            state_d = MWAIT;
          end else if (hz) begin
            // The first stall cycle is spent here; LSTALL covers the remainder.
            mode = M_STALL;
            if (STALL_CYCLES > 1) begin
              state_d = LSTALL;
              cnt_d   = CNT_INIT;
            end
          end else begin
            mode     = M_NORMAL;
            flush_ok = 1'b1;
          end
        end
        LSTALL: begin
          if (bus.dmem_busy) begin
            mode = M_FREEZE;
          end else begin
            mode  = M_STALL;
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = RUN;
          end
        end
        MWAIT: begin
          // Leaving a freeze: operands are stale, so hazards and branches are ignored.
          if (bus.dmem_busy) begin
            mode = M_FREEZE;
          end else begin
            mode    = M_NORMAL;
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.pc_write    = (mode == M_NORMAL);
    bus.ifid_write  = (mode == M_NORMAL);
    bus.ifid_flush  = (mode == M_IDLE) || ((mode == M_NORMAL) && flush_ok && bus.branch_taken);
    bus.idex_bubble = (mode == M_IDLE) || (mode == M_STALL);
    bus.pipe_hold   = (mode == M_FREEZE);
    bus.state       = state_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_SCHED_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((mode == M_STALL) && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if ((state_q == RUN) && bus.start && bus.ifid_flush && (flush_cnt_q != 32'hFFFF_FFFF))
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
